// File: rtl/ceas_timp_counter.sv
// ceas_timp_counter
//   24-hour time-of-day counter (HH:MM:SS). A prescaler divides the system
//   clock down to a one-second edge; seconds, minutes and hours all carry in
//   that same edge. A new HH:MM can be loaded with a range check, and the
//   count can be paused.
//
// Ports
//   clock           in   system clock, all state updates on rising edge
//   reset           in   synchronous reset, active-low
//   enable          in   1 = time advances, 0 = prescaler and time hold
//   load            in   strobe: load ore_setare:minute_setare (secunde=0)
//   minute_setare   in   minute to load, legal 0..59
//   ore_setare      in   hour to load, legal 0..23
//   secunde_counter out  current second 0..59
//   minute_counter  out  current minute 0..59
//   ore_counter     out  current hour 0..23
//   sec_tick        out  pulse in the cycle the new second is visible
//   minute_tick     out  pulse in the cycle the new minute is visible
//   day_tick        out  pulse in the cycle 00:00:00 becomes visible
//   load_err        out  pulse when a load request is out of range
module ceas_timp_counter #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned PRESC_W       = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [5:0] minute_setare,
  input  logic [4:0] ore_setare,
  output logic [5:0] secunde_counter,
  output logic [5:0] minute_counter,
  output logic [4:0] ore_counter,
  output logic       sec_tick,
  output logic       minute_tick,
  output logic       day_tick,
  output logic       load_err
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         sec_q, sec_d;
  logic [5:0]         min_q, min_d;
  logic [4:0]         hr_q, hr_d;
  logic               sec_tick_q, sec_tick_d;
  logic               min_tick_q, min_tick_d;
  logic               day_tick_q, day_tick_d;
  logic               load_err_q, load_err_d;
  logic               load_ok;

  assign load_ok = load && (minute_setare <= 6'd59) && (ore_setare <= 5'd23);

  always_comb begin
    presc_d    = presc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    day_tick_d = 1'b0;
    load_err_d = 1'b0;

    if (load_ok) begin
      // A valid load also swallows any second edge due in this cycle.
      presc_d = '0;
      sec_d   = '0;
      min_d   = minute_setare;
      hr_d    = ore_setare;
    end else begin
      // A rejected load behaves exactly like no load, apart from the flag.
      load_err_d = load;
      if (enable) begin
        if (presc_q == PRESC_LAST) begin
          presc_d    = '0;
          sec_tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d      = '0;
            min_tick_d = 1'b1;
            if (min_q == 6'd59) begin
              min_d = '0;
              if (hr_q == 5'd23) begin
                hr_d       = '0;
                day_tick_d = 1'b1;
              end else begin
                hr_d = hr_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      day_tick_q <= day_tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign secunde_counter = sec_q;
  assign minute_counter  = min_q;
  assign ore_counter     = hr_q;
  assign sec_tick        = sec_tick_q;
  assign minute_tick     = min_tick_q;
  assign day_tick        = day_tick_q;
  assign load_err        = load_err_q;

endmodule
